// File: rtl/capture_sequencer.sv
// -----------------------------------------------------------------------------
// capture_sequencer
//
// Triggered sample capture with UART-style readout. An arm command starts
// watching the decimated ADC stream for a rising crossing of trig_level (or a
// force command, or a strobe-count timeout). DEPTH samples are then captured
// into an internal RAM and streamed out as a 0xA5 header byte followed by the
// buffer contents, using a valid/ready handshake. An abort command returns to
// IDLE from any state.
//
// Parameters
//   DEPTH    samples per capture (power of 2, 16..1024)
//   DECIM    clk cycles per sample strobe (>= 1)
//   TIMEOUT  strobes spent in ARMED before an automatic trigger
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   adc_data    ADC sample, valid every clk
//   trig_level  unsigned trigger threshold
//   rx_valid    one-cycle pulse qualifying rx_data
//   rx_data     command byte: 0x41 arm, 0x46 force, 0x58 abort
//   tx_ready    downstream transmitter can accept a byte
//   tx_valid    tx_data holds a byte to send
//   tx_data     byte to send
//   status      current state (IDLE=0 ARMED=1 CAPTURE=2 SEND_HDR=3 SEND_DATA=4)
// -----------------------------------------------------------------------------
module capture_sequencer #(
  parameter int DEPTH   = 256,
  parameter int DECIM   = 1,
  parameter int TIMEOUT = 27000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] adc_data,
  input  logic [7:0] trig_level,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_ready,
  output logic       tx_valid,
  output logic [7:0] tx_data,
  output logic [2:0] status
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [7:0] CMD_ARM   = 8'h41;
  localparam logic [7:0] CMD_FORCE = 8'h46;
  localparam logic [7:0] CMD_ABORT = 8'h58;
  localparam logic [7:0] HDR_BYTE  = 8'hA5;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ARMED     = 3'd1,
    CAPTURE   = 3'd2,
    SEND_HDR  = 3'd3,
    SEND_DATA = 3'd4
  } state_t;

  state_t          state, next_state;
  logic [DW-1:0]   dec_cnt;
  logic [TW-1:0]   to_cnt;
  logic [7:0]      prev;
  logic            prev_valid;
  logic [AW-1:0]   waddr;
  logic [AW-1:0]   rd_addr;
  logic            rd_valid;
  logic [7:0]      rd_data;
  logic [7:0]      mem [DEPTH];
  logic            mem_we;
  logic            mem_re;

  // Command decode
  logic cmd_arm, cmd_force, cmd_abort;
  assign cmd_arm   = rx_valid && (rx_data == CMD_ARM);
  assign cmd_force = rx_valid && (rx_data == CMD_FORCE);
  assign cmd_abort = rx_valid && (rx_data == CMD_ABORT);

  // The decimation counter free-runs through ARMED and CAPTURE, so the
  // capture keeps the same strobe phase that was established on arming.
  logic strobe, crossing, timeout_hit, last_write, last_read, arm_entry;
  assign strobe      = (dec_cnt == DW'(DECIM - 1));
  assign crossing    = (state == ARMED) && strobe && prev_valid &&
                       (prev < trig_level) && (adc_data >= trig_level);
  assign timeout_hit = (state == ARMED) && strobe && (to_cnt == TW'(TIMEOUT - 1));
  assign last_write  = (state == CAPTURE) && strobe && (waddr == AW'(DEPTH - 1));
  assign last_read   = rd_valid && tx_ready && (rd_addr == AW'(DEPTH - 1));
  assign arm_entry   = (state == IDLE) && (next_state == ARMED);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns next_state and no latch forms.
    next_state = state;
    case (state)
      IDLE:      if (cmd_arm) next_state = ARMED;
      ARMED:     if (crossing || cmd_force || timeout_hit) next_state = CAPTURE;
      CAPTURE:   if (last_write) next_state = SEND_HDR;
      SEND_HDR:  if (tx_ready) next_state = SEND_DATA;
      SEND_DATA: if (last_read) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
    // Abort wins over any trigger or transfer in the same cycle.
    if (cmd_abort) next_state = IDLE;
  end

  // Output logic
  always_comb begin
    status   = state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    mem_we   = 1'b0;
    mem_re   = 1'b0;
    case (state)
      ARMED:     mem_we = crossing && !cmd_abort;  // crossing sample lands at address 0
      CAPTURE:   mem_we = strobe && !cmd_abort;
      SEND_HDR: begin
        tx_valid = 1'b1;
        tx_data  = HDR_BYTE;
      end
      SEND_DATA: begin
        tx_valid = rd_valid;
        tx_data  = rd_valid ? rd_data : 8'h00;
        mem_re   = !rd_valid;
      end
      default: ;
    endcase
  end

  // Counters, trigger history and read pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dec_cnt    <= '0;
      to_cnt     <= '0;
      prev       <= 8'h00;
      prev_valid <= 1'b0;
      waddr      <= '0;
      rd_addr    <= '0;
      rd_valid   <= 1'b0;
    end else begin
      if (arm_entry) begin
        dec_cnt    <= '0;
        to_cnt     <= '0;
        prev       <= 8'h00;
        prev_valid <= 1'b0;
        waddr      <= '0;
      end else if (state == ARMED || state == CAPTURE) begin
        dec_cnt <= strobe ? '0 : dec_cnt + 1'b1;
        if (state == ARMED && strobe) begin
          prev       <= adc_data;
          prev_valid <= 1'b1;
          to_cnt     <= to_cnt + 1'b1;
        end
        if (mem_we) waddr <= waddr + 1'b1;
      end

      // One bubble cycle per byte: fetch from RAM, then hold until accepted.
      if (state == SEND_HDR) begin
        rd_addr  <= '0;
        rd_valid <= 1'b0;
      end else if (state == SEND_DATA) begin
        if (!rd_valid) begin
          rd_valid <= 1'b1;
        end else if (tx_ready) begin
          rd_valid <= 1'b0;
          rd_addr  <= rd_addr + 1'b1;
        end
      end
    end
  end

  // Capture RAM with registered read port
  always_ff @(posedge clk) begin
    // NOTE: the RAM and its read register carry no reset; contents are only
    // observed after being written, and a reset-free array maps onto block RAM.
    if (mem_we) mem[waddr] <= adc_data;
    if (mem_re) rd_data <= mem[rd_addr];
  end

endmodule

// File: tb/tb_capture_sequencer.sv
// -----------------------------------------------------------------------------
// tb_capture_sequencer
//
// Drives two capture_sequencer instances (DECIM=1 and DECIM=4, DEPTH=16,
// TIMEOUT=100) from one directed sequence. Every sample applied after an arm
// command is logged; a reference model derives the trigger strobe and the
// expected frame from that log using the trigger rules directly.
// -----------------------------------------------------------------------------
module tb_capture_sequencer;

  localparam int DEPTH = 16;
  localparam int TMO   = 100;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0][7:0]  adc, lvl, rxd;
  logic [1:0]       rxv, txr;
  wire  [1:0]       txv;
  wire  [1:0][7:0]  txd;
  wire  [1:0][2:0]  st;

  always #5 clk = ~clk;

  capture_sequencer #(.DEPTH(DEPTH), .DECIM(1), .TIMEOUT(TMO)) u_d1 (
    .clk(clk), .rst(rst), .adc_data(adc[0]), .trig_level(lvl[0]),
    .rx_valid(rxv[0]), .rx_data(rxd[0]), .tx_ready(txr[0]),
    .tx_valid(txv[0]), .tx_data(txd[0]), .status(st[0])
  );

  capture_sequencer #(.DEPTH(DEPTH), .DECIM(4), .TIMEOUT(TMO)) u_d4 (
    .clk(clk), .rst(rst), .adc_data(adc[1]), .trig_level(lvl[1]),
    .rx_valid(rxv[1]), .rx_data(rxd[1]), .tx_ready(txr[1]),
    .tx_valid(txv[1]), .tx_data(txd[1]), .status(st[1])
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  smp[$];
  logic [7:0]  got[$];
  bit          log_on  = 1'b0;
  int          log_sel = 0;
  int          j_cnt   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One clock: log the sample the edge will see, then return at the negedge.
  task automatic tick();
    if (log_on) smp.push_back(adc[log_sel]);
    @(posedge clk);
    @(negedge clk);
    rxv   = '0;
    j_cnt = j_cnt + 1;
  endtask

  task automatic cmd(input int sel, input logic [7:0] c);
    rxd[sel] = c;
    rxv[sel] = 1'b1;
    tick();
  endtask

  task automatic arm(input int sel);
    cmd(sel, 8'h41);
    smp.delete();
    j_cnt   = 0;
    log_sel = sel;
    log_on  = 1'b1;
    check("arm_status", st[sel], 3'd1);
  endtask

  // mode 0: ramp +0x10/clk, 1: random, 2: constant 0x20, 3: random below 0xFF
  task automatic drive_adc(input int sel, input int mode);
    case (mode)
      0:       adc[sel] = adc[sel] + 8'h10;
      1:       adc[sel] = 8'($urandom_range(0, 255));
      2:       adc[sel] = 8'h20;
      default: adc[sel] = 8'($urandom_range(0, 254));
    endcase
  endtask

  // Runs from ARMED until SEND_HDR is observed. force_j / noise_a / noise_f
  // give the tick index (counted from the arm edge) for a force command, an
  // inapplicable arm command and an inapplicable force command.
  task automatic run_capture(input int sel, input int mode, input int force_j,
                             input int noise_a, input int noise_f, output int j_hdr);
    logic [2:0] pre;
    j_hdr = -1;
    for (int c = 0; c < 600; c++) begin
      drive_adc(sel, mode);
      pre = st[sel];
      if (j_cnt + 1 == force_j) begin
        rxd[sel] = 8'h46; rxv[sel] = 1'b1;
      end else if (j_cnt + 1 == noise_a) begin
        rxd[sel] = 8'h41; rxv[sel] = 1'b1;
      end else if (j_cnt + 1 == noise_f) begin
        rxd[sel] = 8'h46; rxv[sel] = 1'b1;
      end
      tick();
      if (j_cnt == noise_a || j_cnt == noise_f) check("ignored_cmd_status", st[sel], pre);
      if (st[sel] == 3'd3) begin
        j_hdr = j_cnt;
        break;
      end
    end
    log_on = 1'b0;
    check("reached_send_hdr", 32'(j_hdr > 0), 32'd1);
  endtask

  function automatic logic [7:0] samp(input int idx);
    if (idx >= 0 && idx < smp.size()) return smp[idx];
    return 8'hxx;
  endfunction

  // Strobe k lands on edge k*d after the arm edge; returns the strobe number
  // whose sample is written to address 0.
  function automatic int find_start(input int d, input logic [7:0] lv, input int force_j);
    for (int k = 1; k <= TMO; k++) begin
      int e;
      e = k * d;
      if (force_j > 0 && force_j < e) return k;
      if (k >= 2 && samp((k - 1) * d - 1) < lv && samp(e - 1) >= lv) return k;
      if (force_j == e) return k + 1;
    end
    return TMO + 1;
  endfunction

  task automatic drain(input int sel, input bit rnd, input int abort_at);
    bit         stall = 1'b0;
    logic [7:0] held  = 8'h00;
    int         gap   = 0;
    bit         done  = 1'b0;
    got.delete();
    for (int c = 0; c < 400 && !done; c++) begin
      if (stall) begin
        check("stall_valid", txv[sel], 1'b1);
        check("stall_data", txd[sel], held);
      end
      if (abort_at > 0 && got.size() == abort_at) begin
        rxd[sel] = 8'h58; rxv[sel] = 1'b1; txr[sel] = 1'b1;
        tick();
        check("abort_tx_valid", txv[sel], 1'b0);
        check("abort_status", st[sel], 3'd0);
        txr[sel] = 1'b0;
        return;
      end
      txr[sel] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      gap = txv[sel] ? 0 : gap + 1;
      check("valid_latency_ok", 32'(gap <= 2), 32'd1);
      stall = txv[sel] && !txr[sel];
      held  = txd[sel];
      if (txv[sel] && txr[sel]) got.push_back(txd[sel]);
      tick();
      done = (st[sel] == 3'd0);
    end
    txr[sel] = 1'b0;
    check("back_to_idle", st[sel], 3'd0);
  endtask

  task automatic verify_frame(input int start, input int d, input int j_hdr);
    check("hdr_timing", j_hdr, (start + DEPTH - 1) * d);
    check("frame_len", got.size(), DEPTH + 1);
    if (got.size() > 0) check("hdr_byte", got[0], 8'hA5);
    for (int i = 0; i < DEPTH; i++)
      if (i + 1 < got.size())
        check($sformatf("data%0d", i), got[i + 1], samp((start + i) * d - 1));
  endtask

  initial begin
    int jh, s;
    rst = 1'b1;
    adc = '0; lvl = '0; rxd = '0; rxv = '0; txr = '0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_status", st[i], 3'd0);
      check("rst_tx_valid", txv[i], 1'b0);
      check("rst_tx_data", txd[i], 8'h00);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    // Only arm leaves IDLE
    cmd(0, 8'h46); check("idle_force_ignored", st[0], 3'd0);
    cmd(0, 8'h55); check("idle_junk_ignored", st[0], 3'd0);
    cmd(1, 8'h58); check("idle_abort_stays", st[1], 3'd0);

    // Ramp crossing at 0x80
    lvl[0] = 8'h80; adc[0] = 8'hF0;
    arm(0);
    run_capture(0, 0, 0, 0, 0, jh);
    s = find_start(1, lvl[0], 0);
    drain(0, 1'b0, 0);
    verify_frame(s, 1, jh);
    if (got.size() > 1) check("ramp_first_byte", got[1], 8'h80);

    // Random data, random level, random back-pressure
    for (int r = 0; r < 2; r++) begin
      lvl[0] = 8'($urandom_range(8'h40, 8'hC0));
      arm(0);
      run_capture(0, 1, 0, 0, 0, jh);
      s = find_start(1, lvl[0], 0);
      drain(0, 1'b1, 0);
      verify_frame(s, 1, jh);
    end

    // Timeout with constant input
    lvl[0] = 8'h80;
    arm(0);
    run_capture(0, 2, 0, 0, 0, jh);
    s = find_start(1, lvl[0], 0);
    drain(0, 1'b1, 0);
    verify_frame(s, 1, jh);

    // Abort during SEND_DATA after five data bytes, then a fresh frame
    adc[0] = 8'hF0;
    arm(0);
    run_capture(0, 0, 0, 0, 0, jh);
    drain(0, 1'b0, 6);
    tick();
    check("post_abort_idle", st[0], 3'd0);
    check("post_abort_tx_valid", txv[0], 1'b0);
    adc[0] = 8'hF0;
    arm(0);
    run_capture(0, 0, 0, 0, 0, jh);
    s = find_start(1, lvl[0], 0);
    drain(0, 1'b0, 0);
    verify_frame(s, 1, jh);

    // DECIM=4 force trigger; stray arm/force commands ignored
    lvl[1] = 8'hFF;
    arm(1);
    run_capture(1, 3, 6, 2, 12, jh);
    cmd(1, 8'h41); check("hdr_arm_ignored", st[1], 3'd3);
    cmd(1, 8'h46); check("hdr_force_ignored", st[1], 3'd3);
    s = find_start(4, lvl[1], 6);
    drain(1, 1'b1, 0);
    verify_frame(s, 4, jh);

    // Asynchronous reset during CAPTURE
    lvl[0] = 8'h80; adc[0] = 8'hF0;
    arm(0);
    for (int c = 0; c < 50 && st[0] != 3'd2; c++) begin
      drive_adc(0, 0);
      tick();
    end
    log_on = 1'b0;
    check("in_capture", st[0], 3'd2);
    #2 rst = 1'b1;
    #1;
    check("async_rst_status", st[0], 3'd0);
    check("async_rst_tx_valid", txv[0], 1'b0);
    check("async_rst_tx_data", txd[0], 8'h00);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_adc(0, 0);
      tick();
      check("idle_after_rst", st[0], 3'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
